pmem_line_responder: RTL



---
 rtl/pmem_resp_pkg.sv | 19 +
 rtl/pmem_line_responder_if.sv | 22 ++
 rtl/pmem_line_array.sv | 47 ++++
 rtl/pmem_line_responder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pmem_resp_pkg.sv
// Shared types and constants for the line-granular pmem responder.
package pmem_resp_pkg;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;
    localparam int LAT_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Counter load value for a given access latency.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
        return LAT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/pmem_line_responder_if.sv
// Cache-to-memory line request bus: one outstanding read or write, single-cycle response.
interface pmem_line_responder_if;
    import pmem_resp_pkg::*;

    logic                 pmem_read;
    logic                 pmem_write;
    logic [31:0]          pmem_address;
    logic [LINE_BITS-1:0] pmem_wdata;
    logic [LINE_BITS-1:0] pmem_rdata;
    logic                 pmem_resp;
    logic                 proto_err;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp, proto_err
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp, proto_err
    );
endinterface

// File: rtl/pmem_line_array.sv
// Line storage: synchronous write, read registered into the output (1 cycle, contents never reset).
// No backpressure: write and read enables are honoured every cycle.
module pmem_line_array
    import pmem_resp_pkg::*;
#(
    parameter int LINES = 256,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [LINE_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [IDX_W-1:0]     raddr,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem [LINES];
    logic [LINE_BITS-1:0] rdata_q;
    logic [LINE_BITS-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register only moves on a read, so it survives intervening writes.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem_line_responder.sv
// DRAM stand-in answering line reads/writes after READ_LAT/WRITE_LAT cycles; one request at a time,
// requester holds the request until pmem_resp. Optional checker under PMEM_RESP_PROTO_CHECK_EN.
module pmem_line_responder
    import pmem_resp_pkg::*;
#(
    parameter int LINES     = 256,
    parameter int READ_LAT  = 10,
    parameter int WRITE_LAT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pmem_line_responder_if.slave bus
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [LAT_CNT_W-1:0] READ_M1  = lat_load(READ_LAT);
    localparam logic [LAT_CNT_W-1:0] WRITE_M1 = lat_load(WRITE_LAT);

    state_e               state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 op_wr_q, op_wr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;

    logic [IDX_W-1:0]     req_idx;
    logic                 req_any;
    logic [LAT_CNT_W-1:0] lat_m1;
    logic                 arr_we;
    logic                 arr_re;
    logic [LINE_BITS-1:0] arr_rdata;

    assign req_idx = bus.pmem_address[OFFSET_BITS +: IDX_W];
    assign req_any = bus.pmem_read | bus.pmem_write;
    // A simultaneous read+write is resolved as a write.
    assign lat_m1  = bus.pmem_write ? WRITE_M1 : READ_M1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    op_wr_d = bus.pmem_write;
                    idx_d   = req_idx;
                    wdata_d = bus.pmem_wdata;
                    cnt_d   = lat_m1;
                    state_d = (lat_m1 == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Leaving on the 1->0 step puts the response exactly LAT cycles after acceptance.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAT_CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Read data is fetched on the edge that enters RESP so it is visible during the pulse.
    assign arr_we = (state_q == RESP) && op_wr_q;
    assign arr_re = (state_d == RESP) && !op_wr_d;

    pmem_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .re    (arr_re),
        .raddr (idx_d),
        .rdata (arr_rdata)
    );

    assign bus.pmem_rdata = arr_rdata;
    assign bus.pmem_resp  = (state_q == RESP);

`ifdef PMEM_RESP_PROTO_CHECK_EN
    logic proto_err_q, proto_err_d;
    logic viol;

    always_comb begin
        viol = 1'b0;
        case (state_q)
            IDLE: viol = bus.pmem_read & bus.pmem_write;
            WAIT, RESP: begin
                if (op_wr_q) begin
                    viol = !bus.pmem_write || bus.pmem_read ||
                           (req_idx != idx_q) || (bus.pmem_wdata != wdata_q);
                end else begin
                    viol = !bus.pmem_read || bus.pmem_write || (req_idx != idx_q);
                end
            end
            default: viol = 1'b0;
        endcase
        proto_err_d = proto_err_q | viol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.proto_err = proto_err_q;
`else
    assign bus.proto_err = 1'b0;
`endif

endmodule
